// File: rtl/ex_mem_skid_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_skid_stage
//
// This is the EX/MEM pipeline boundary. It has a parameterised control word,
// data word and destination-register index. Beats pass through a two-entry
// skid buffer that uses a valid/ready handshake. The main entry drives the
// out_* ports straight from flops. The skid entry absorbs the one beat that
// can arrive while MEM is stalling. Because of this, in_ready depends only on
// local flops and flush. It never depends on out_ready.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   flush      kill every held entry this cycle (hazard flush)
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat
//   in_ctrl    control field in   (CTRL_W)
//   in_data    data field in      (DATA_W)
//   in_rd      dest reg index in  (RD_W)
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_ctrl   control field out  (CTRL_W), zero whenever out_valid is low
//   out_data   data field out     (DATA_W)
//   out_rd     dest reg index out (RD_W)
//   occupancy  number of held entries, 0..2
//   flush_cnt  saturating count of flushes that killed at least one entry
// ----------------------------------------------------------------------------
module ex_mem_skid_stage #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              m_v_q,    m_v_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [RD_W-1:0]   m_rd_q,   m_rd_d;

  logic              s_v_q,    s_v_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [RD_W-1:0]   s_rd_q,   s_rd_d;

  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic acc;
  logic pop;

  // A full skid means the one spare slot is already taken. A flush refuses
  // new beats so that nothing enters in the same cycle that the stage is
  // emptied.
  assign in_ready = ~s_v_q & ~flush;
  assign acc      = in_valid & in_ready;
  assign pop      = m_v_q & out_ready;

  // Next-state logic. Flush overrides the normal update. Any entry that goes
  // invalid has its ctrl cleared, so downstream may use out_ctrl without
  // gating it by valid. The data and rd fields keep their last values.
  always_comb begin
    m_v_d       = m_v_q;
    m_ctrl_d    = m_ctrl_q;
    m_data_d    = m_data_q;
    m_rd_d      = m_rd_q;
    s_v_d       = s_v_q;
    s_ctrl_d    = s_ctrl_q;
    s_data_d    = s_data_q;
    s_rd_d      = s_rd_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      m_v_d    = 1'b0;
      s_v_d    = 1'b0;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      if ((m_v_q | s_v_q) && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end else if (!m_v_q || (pop && !s_v_q)) begin
      // Main is empty or draining with no skid behind it, so the input can
      // go straight to the output register.
      if (acc) begin
        m_v_d    = 1'b1;
        m_ctrl_d = in_ctrl;
        m_data_d = in_data;
        m_rd_d   = in_rd;
      end else begin
        m_v_d    = 1'b0;
        m_ctrl_d = '0;
      end
    end else if (s_v_q && pop) begin
      // Main drains and the skid moves forward. No beat can be accepted in
      // this cycle because in_ready is low while the skid is valid.
      m_v_d    = 1'b1;
      m_ctrl_d = s_ctrl_q;
      m_data_d = s_data_q;
      m_rd_d   = s_rd_q;
      s_v_d    = 1'b0;
      s_ctrl_d = '0;
    end else if (acc) begin
      // Main is stalled, so the new beat parks in the skid entry.
      s_v_d    = 1'b1;
      s_ctrl_d = in_ctrl;
      s_data_d = in_data;
      s_rd_d   = in_rd;
    end
  end

  // State flops. Reset takes priority over everything else, including a
  // flush in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_v_q       <= 1'b0;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      m_rd_q      <= '0;
      s_v_q       <= 1'b0;
      s_ctrl_q    <= '0;
      s_data_q    <= '0;
      s_rd_q      <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_v_q       <= m_v_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      m_rd_q      <= m_rd_d;
      s_v_q       <= s_v_d;
      s_ctrl_q    <= s_ctrl_d;
      s_data_q    <= s_data_d;
      s_rd_q      <= s_rd_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid = m_v_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign out_rd    = m_rd_q;
  assign occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};
  assign flush_cnt = flush_cnt_q;

`ifndef SYNTHESIS
  // The skid only fills while main is held, so a lone valid skid means the
  // state has been corrupted.
  skid_implies_main: assert property (@(posedge clk) disable iff (reset)
    s_v_q |-> m_v_q);
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_skid_stage
//
// Directed bench for ex_mem_skid_stage. The stimulus pushes each beat it
// expects the stage to accept into a scoreboard queue. A separate monitor pops
// and compares the queue whenever the stage hands a beat downstream. A second
// instance with a 2-bit flush counter shares the same inputs and is used to
// check counter saturation.
// ----------------------------------------------------------------------------
module tb_ex_mem_skid_stage;

  typedef struct packed {
    logic [7:0]   ctrl;
    logic [127:0] data;
    logic [4:0]   rd;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_ctrl;
  logic [127:0] in_data;
  logic [4:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_ctrl;
  logic [127:0] out_data;
  logic [4:0]   out_rd;
  logic [1:0]   occupancy;
  logic [15:0]  flush_cnt;

  logic         sat_in_ready;
  logic         sat_out_valid;
  logic [7:0]   sat_out_ctrl;
  logic [127:0] sat_out_data;
  logic [4:0]   sat_out_rd;
  logic [1:0]   sat_occupancy;
  logic [1:0]   sat_flush_cnt;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  logic  pending_clear = 1'b0;

  localparam logic [127:0] DATA_X1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222;
  localparam logic [127:0] DATA_X2 = 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_3333_4444;

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .occupancy (occupancy),
    .flush_cnt (flush_cnt)
  );

  ex_mem_skid_stage #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (sat_out_ctrl),
    .out_data  (sat_out_data),
    .out_rd    (sat_out_rd),
    .occupancy (sat_occupancy),
    .flush_cnt (sat_flush_cnt)
  );

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then return at the
  // falling edge so that the caller can check outputs. Beats whose entries were
  // killed by the previous flush or reset are dropped from the scoreboard.
  task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                               input logic [7:0] ctrl, input logic [127:0] data,
                               input logic [4:0] rd, input logic ordy,
                               input logic exp_acc);
    beat_t b;
    @(posedge clk);
    if (pending_clear) exp_q.delete();
    #1;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = ctrl;
    in_data   = data;
    in_rd     = rd;
    out_ready = ordy;
    pending_clear = fl | rst;
    if (exp_acc) begin
      b.ctrl = ctrl;
      b.data = data;
      b.rd   = rd;
      exp_q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 5'd0, ordy, 1'b0);
  endtask

  // Monitor. Each handshake that completes at the next edge is checked against
  // the head of the scoreboard. ctrl must be zero whenever valid is low.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!out_valid) checkOutput("ctrl_zero_when_idle", {120'h0, out_ctrl}, 128'h0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat_rd", {123'h0, out_rd}, 128'h0);
            $display("[TB] FAIL unexpected_beat: no beat expected");
          end else begin
            b = exp_q.pop_front();
            checkOutput("beat_ctrl", {120'h0, out_ctrl}, {120'h0, b.ctrl});
            checkOutput("beat_data", out_data, b.data);
            checkOutput("beat_rd", {123'h0, out_rd}, {123'h0, b.rd});
          end
        end
      end
    end
  end

  // Watchdog, so that a broken run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0;
    in_data = '0; in_rd = '0; out_ready = 1'b0;

    // Reset, then check the idle state of the stage.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 128'h0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 128'h0, 5'd0, 1'b0, 1'b0);
    idle(1'b0);
    checkOutput("rst_out_valid", {127'h0, out_valid}, 128'h0);
    checkOutput("rst_out_ctrl",  {120'h0, out_ctrl}, 128'h0);
    checkOutput("rst_out_data",  out_data, 128'h0);
    checkOutput("rst_out_rd",    {123'h0, out_rd}, 128'h0);
    checkOutput("rst_occupancy", {126'h0, occupancy}, 128'h0);
    checkOutput("rst_flush_cnt", {112'h0, flush_cnt}, 128'h0);
    checkOutput("rst_in_ready",  {127'h0, in_ready}, 128'h1);

    // Stream 4 beats with out_ready high. Each beat appears one cycle later.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 128'(k), 5'(k), 1'b1, 1'b1);
      checkOutput("stream_in_ready", {127'h0, in_ready}, 128'h1);
      checkOutput("stream_occupancy", {126'h0, occupancy}, (k == 1) ? 128'h0 : 128'h1);
      if (k > 1) begin
        checkOutput("stream_out_valid", {127'h0, out_valid}, 128'h1);
        checkOutput("stream_latency_rd", {123'h0, out_rd}, 128'(k - 1));
      end
    end
    idle(1'b1);
    checkOutput("stream_last_rd", {123'h0, out_rd}, 128'h4);
    idle(1'b1);
    checkOutput("stream_empty_valid", {127'h0, out_valid}, 128'h0);
    checkOutput("stream_empty_occ", {126'h0, occupancy}, 128'h0);

    // Back-pressure fills the skid, then the beats drain in order.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h11, 128'd7, 5'd7, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 128'd9, 5'd9, 1'b0, 1'b1);
    idle(1'b0);
    checkOutput("bp_occupancy_full", {126'h0, occupancy}, 128'h2);
    checkOutput("bp_in_ready_low", {127'h0, in_ready}, 128'h0);
    idle(1'b1);
    checkOutput("bp_first_rd", {123'h0, out_rd}, 128'h7);
    checkOutput("bp_in_ready_still_low", {127'h0, in_ready}, 128'h0);
    idle(1'b1);
    checkOutput("bp_second_rd", {123'h0, out_rd}, 128'h9);
    checkOutput("bp_in_ready_back", {127'h0, in_ready}, 128'h1);
    checkOutput("bp_occupancy_one", {126'h0, occupancy}, 128'h1);

    // Flush a full stage. data is kept, ctrl and valid are cleared.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, DATA_X1, 5'd3, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, DATA_X2, 5'd4, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 128'h0, 5'd0, 1'b0, 1'b0);
    checkOutput("fl_in_ready_low", {127'h0, in_ready}, 128'h0);
    checkOutput("fl_occupancy_before", {126'h0, occupancy}, 128'h2);
    idle(1'b0);
    checkOutput("fl_out_valid", {127'h0, out_valid}, 128'h0);
    checkOutput("fl_out_ctrl", {120'h0, out_ctrl}, 128'h0);
    checkOutput("fl_out_data_kept", out_data, DATA_X1);
    checkOutput("fl_out_rd_kept", {123'h0, out_rd}, 128'h3);
    checkOutput("fl_occupancy", {126'h0, occupancy}, 128'h0);
    checkOutput("fl_cnt_one", {112'h0, flush_cnt}, 128'h1);
    checkOutput("fl_sat_cnt_one", {126'h0, sat_flush_cnt}, 128'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 128'h0, 5'd0, 1'b0, 1'b0);
    idle(1'b0);
    checkOutput("fl_empty_no_count", {112'h0, flush_cnt}, 128'h1);

    // A flush blocks a presented beat, and the re-presented beat is accepted.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h33, 128'h55, 5'd5, 1'b1, 1'b0);
    checkOutput("flin_in_ready_low", {127'h0, in_ready}, 128'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 128'h55, 5'd5, 1'b1, 1'b1);
    checkOutput("flin_in_ready_high", {127'h0, in_ready}, 128'h1);
    checkOutput("flin_not_captured", {127'h0, out_valid}, 128'h0);
    idle(1'b1);
    checkOutput("flin_out_valid", {127'h0, out_valid}, 128'h1);
    checkOutput("flin_out_rd", {123'h0, out_rd}, 128'h5);
    checkOutput("flin_cnt_unchanged", {112'h0, flush_cnt}, 128'h1);

    // Five flushes on an occupied stage. The 2-bit counter sticks at 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h40, 128'(i), 5'(20 + i), 1'b0, 1'b1);
      checkOutput("sat_cnt_wide", {112'h0, flush_cnt}, 128'(1 + i));
      checkOutput("sat_cnt_narrow", {126'h0, sat_flush_cnt}, (i >= 2) ? 128'h3 : 128'(1 + i));
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 128'h0, 5'd0, 1'b0, 1'b0);
    end
    idle(1'b0);
    checkOutput("sat_cnt_wide_final", {112'h0, flush_cnt}, 128'h6);
    checkOutput("sat_cnt_narrow_final", {126'h0, sat_flush_cnt}, 128'h3);

    // Reset together with flush on a full stage. Reset wins.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 128'd10, 5'd10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h78, 128'd11, 5'd11, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 128'h0, 5'd0, 1'b0, 1'b0);
    checkOutput("mr_occupancy_before", {126'h0, occupancy}, 128'h2);
    idle(1'b0);
    checkOutput("mr_out_valid", {127'h0, out_valid}, 128'h0);
    checkOutput("mr_out_ctrl", {120'h0, out_ctrl}, 128'h0);
    checkOutput("mr_out_data", out_data, 128'h0);
    checkOutput("mr_out_rd", {123'h0, out_rd}, 128'h0);
    checkOutput("mr_occupancy", {126'h0, occupancy}, 128'h0);
    checkOutput("mr_flush_cnt", {112'h0, flush_cnt}, 128'h0);
    checkOutput("mr_sat_flush_cnt", {126'h0, sat_flush_cnt}, 128'h0);
    checkOutput("mr_in_ready", {127'h0, in_ready}, 128'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 128'd12, 5'd12, 1'b1, 1'b1);
    idle(1'b1);
    checkOutput("mr_next_valid", {127'h0, out_valid}, 128'h1);
    checkOutput("mr_next_rd", {123'h0, out_rd}, 128'hC);
    idle(1'b1);
    idle(1'b1);

    checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
